// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode/issue slice.
// Opcode classes, field positions and the source/destination usage decoder.
package decode_pkg;

  localparam logic [3:0] CLS_ALUR   = 4'h0;
  localparam logic [3:0] CLS_ALUI   = 4'h8;
  localparam logic [3:0] CLS_LOAD   = 4'h9;
  localparam logic [3:0] CLS_STORE  = 4'h5;
  localparam logic [3:0] CLS_BRANCH = 4'h2;
  localparam logic [3:0] CLS_JAL    = 4'hB;

  localparam int OP_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;

  typedef struct packed {
    logic rd1;
    logic rd2;
    logic wr;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] cls);
    dec_t d;
    d = '0;
    case (cls)
      CLS_ALUR:   d = '{rd1: 1'b1, rd2: 1'b1, wr: 1'b1};
      CLS_ALUI:   d = '{rd1: 1'b1, rd2: 1'b0, wr: 1'b1};
      CLS_LOAD:   d = '{rd1: 1'b1, rd2: 1'b0, wr: 1'b1};
      CLS_STORE:  d = '{rd1: 1'b1, rd2: 1'b1, wr: 1'b0};
      CLS_BRANCH: d = '{rd1: 1'b1, rd2: 1'b1, wr: 1'b0};
      CLS_JAL:    d = '{rd1: 1'b1, rd2: 1'b0, wr: 1'b1};
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_stage_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register.
// Query outputs already discount a same-cycle writeback.
module decode_issue_stage_scoreboard
  import decode_pkg::*;
#(
  parameter int REG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_i,
  input  logic [REG_WIDTH-1:0] set_idx_i,
  input  logic                 wb_we_i,
  input  logic [REG_WIDTH-1:0] wb_idx_i,
  input  logic                 fl_clr_i,
  input  logic [REG_WIDTH-1:0] fl_idx_i,
  input  logic [REG_WIDTH-1:0] q_rs1_i,
  input  logic [REG_WIDTH-1:0] q_rs2_i,
  input  logic [REG_WIDTH-1:0] q_rd_i,
  output logic                 busy_rs1_o,
  output logic                 busy_rs2_o,
  output logic                 busy_rd_o
);

  localparam int NREG = 1 << REG_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] eff;
  logic [NREG-1:0] wb_m;
  logic [NREG-1:0] fl_m;
  logic [NREG-1:0] set_m;

  assign wb_m  = wb_we_i  ? (NREG'(1) << wb_idx_i)  : '0;
  assign fl_m  = fl_clr_i ? (NREG'(1) << fl_idx_i)  : '0;
  assign set_m = set_i    ? (NREG'(1) << set_idx_i) : '0;

  assign eff = busy_q & ~wb_m;

  // A younger issue wins over any clear of the same register.
  assign busy_d = (busy_q & ~wb_m & ~fl_m) | set_m;

  assign busy_rs1_o = eff[q_rs1_i];
  assign busy_rs2_o = eff[q_rs2_i];
  assign busy_rd_o  = eff[q_rd_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: field decode, scoreboard hazard stall and
// the ID/EX pipeline register with valid/ready on both sides.
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int REG_WIDTH = 4,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IF_VALID,
  output logic                 IF_READY,
  input  logic [BIT_WIDTH-1:0] IF_IR,
  input  logic [BIT_WIDTH-1:0] IF_PC,
  output logic [REG_WIDTH-1:0] RF_SR1,
  output logic [REG_WIDTH-1:0] RF_SR2,
  input  logic [BIT_WIDTH-1:0] RF_SR1OUT,
  input  logic [BIT_WIDTH-1:0] RF_SR2OUT,
  input  logic                 WB_WE,
  input  logic [REG_WIDTH-1:0] WB_DR,
  input  logic                 FLUSH,
  output logic                 EX_VALID,
  input  logic                 EX_READY,
  output logic [7:0]           EX_OP,
  output logic [REG_WIDTH-1:0] EX_DR,
  output logic                 EX_WE,
  output logic [BIT_WIDTH-1:0] EX_A,
  output logic [BIT_WIDTH-1:0] EX_B,
  output logic [BIT_WIDTH-1:0] EX_IMM,
  output logic [BIT_WIDTH-1:0] EX_PC
);

  logic [7:0]           op;
  logic [REG_WIDTH-1:0] rd;
  logic [REG_WIDTH-1:0] rs1;
  logic [REG_WIDTH-1:0] rs2;
  logic [IMM_WIDTH-1:0] imm;
  logic [BIT_WIDTH-1:0] imm_sx;
  dec_t                 dec;

  assign op     = IF_IR[OP_LSB +: 8];
  assign rd     = IF_IR[RD_LSB +: REG_WIDTH];
  assign rs1    = IF_IR[RS1_LSB +: REG_WIDTH];
  assign rs2    = IF_IR[RS2_LSB +: REG_WIDTH];
  assign imm    = IF_IR[IMM_WIDTH-1:0];
  assign imm_sx = {{(BIT_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign dec    = decode(op[7:4]);

  assign RF_SR1 = rs1;
  assign RF_SR2 = rs2;

  logic                 ex_valid_q;
  logic [7:0]           ex_op_q;
  logic [REG_WIDTH-1:0] ex_dr_q;
  logic                 ex_we_q;
  logic [BIT_WIDTH-1:0] ex_a_q;
  logic [BIT_WIDTH-1:0] ex_b_q;
  logic [BIT_WIDTH-1:0] ex_imm_q;
  logic [BIT_WIDTH-1:0] ex_pc_q;

  logic b1, b2, bd;
  logic hazard;
  logic slot_free;
  logic accept;
  logic fl_clr;

  assign hazard = IF_VALID &
                  ((dec.rd1 & b1) | (dec.rd2 & b2) | (dec.wr & bd));

  assign slot_free = ~ex_valid_q | EX_READY;
  assign IF_READY  = RESET_N & slot_free & ~hazard & ~FLUSH;
  assign accept    = IF_VALID & IF_READY;

  // A flushed instruction still parked in EX will never write back.
  assign fl_clr = FLUSH & ex_valid_q & ex_we_q & ~EX_READY;

  decode_issue_stage_scoreboard #(
    .REG_WIDTH (REG_WIDTH)
  ) u_sb (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .set_i      (accept & dec.wr),
    .set_idx_i  (rd),
    .wb_we_i    (WB_WE),
    .wb_idx_i   (WB_DR),
    .fl_clr_i   (fl_clr),
    .fl_idx_i   (ex_dr_q),
    .q_rs1_i    (rs1),
    .q_rs2_i    (rs2),
    .q_rd_i     (rd),
    .busy_rs1_o (b1),
    .busy_rs2_o (b2),
    .busy_rd_o  (bd)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_dr_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
    end else if (FLUSH) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= op;
      ex_dr_q    <= rd;
      ex_we_q    <= dec.wr;
      ex_a_q     <= RF_SR1OUT;
      ex_b_q     <= RF_SR2OUT;
      ex_imm_q   <= imm_sx;
      ex_pc_q    <= IF_PC;
    end else if (EX_READY) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign EX_VALID = ex_valid_q;
  assign EX_OP    = ex_op_q;
  assign EX_DR    = ex_dr_q;
  assign EX_WE    = ex_we_q;
  assign EX_A     = ex_a_q;
  assign EX_B     = ex_b_q;
  assign EX_IMM   = ex_imm_q;
  assign EX_PC    = ex_pc_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: issue, RAW/WAW stalls,
// backpressure, flush and asynchronous reset.
module tb_decode_issue_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic [3:0]  RF_SR1;
  logic [3:0]  RF_SR2;
  logic [31:0] RF_SR1OUT;
  logic [31:0] RF_SR2OUT;
  logic        WB_WE;
  logic [3:0]  WB_DR;
  logic [31:0] wb_data;
  logic        FLUSH;
  logic        EX_VALID;
  logic        EX_READY;
  logic [7:0]  EX_OP;
  logic [3:0]  EX_DR;
  logic        EX_WE;
  logic [31:0] EX_A;
  logic [31:0] EX_B;
  logic [31:0] EX_IMM;
  logic [31:0] EX_PC;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Register file model: value 0x1000_000r, with writeback bypass.
  always_comb begin
    RF_SR1OUT = {28'h1000000, RF_SR1};
    RF_SR2OUT = {28'h1000000, RF_SR2};
    if (WB_WE && WB_DR == RF_SR1) RF_SR1OUT = wb_data;
    if (WB_WE && WB_DR == RF_SR2) RF_SR2OUT = wb_data;
  end

  decode_issue_stage dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IF_VALID  (IF_VALID),
    .IF_READY  (IF_READY),
    .IF_IR     (IF_IR),
    .IF_PC     (IF_PC),
    .RF_SR1    (RF_SR1),
    .RF_SR2    (RF_SR2),
    .RF_SR1OUT (RF_SR1OUT),
    .RF_SR2OUT (RF_SR2OUT),
    .WB_WE     (WB_WE),
    .WB_DR     (WB_DR),
    .FLUSH     (FLUSH),
    .EX_VALID  (EX_VALID),
    .EX_READY  (EX_READY),
    .EX_OP     (EX_OP),
    .EX_DR     (EX_DR),
    .EX_WE     (EX_WE),
    .EX_A      (EX_A),
    .EX_B      (EX_B),
    .EX_IMM    (EX_IMM),
    .EX_PC     (EX_PC)
  );

  function automatic logic [31:0] ins(input logic [7:0] op,
                                      input logic [3:0] rd,
                                      input logic [3:0] rs1,
                                      input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_N  = 1'b0;
    IF_VALID = 1'b1;
    IF_IR    = ins(8'h01, 4'd1, 4'd2, 16'h3000);
    IF_PC    = 32'h0;
    WB_WE    = 1'b0;
    WB_DR    = 4'd0;
    wb_data  = 32'hDEAD_BEEF;
    FLUSH    = 1'b0;
    EX_READY = 1'b1;
    #3;
    chk("rst_if_ready", 64'(IF_READY), 64'd0);
    chk("rst_ex_valid", 64'(EX_VALID), 64'd0);
    chk("rst_busy", 64'(dut.u_sb.busy_q), 64'h0);
    chk("rst_ex_we", 64'(EX_WE), 64'd0);
    IF_VALID = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("post_rst_if_ready", 64'(IF_READY), 64'd1);

    // Back-to-back independent instructions
    tick();
    IF_VALID = 1'b1;
    IF_IR    = ins(8'h01, 4'd1, 4'd2, 16'h3000);
    IF_PC    = 32'h100;
    #1;
    chk("sr1", 64'(RF_SR1), 64'd2);
    chk("sr2", 64'(RF_SR2), 64'd3);
    chk("b2b_ready0", 64'(IF_READY), 64'd1);
    tick();
    chk("b2b0_valid", 64'(EX_VALID), 64'd1);
    chk("b2b0_op", 64'(EX_OP), 64'h01);
    chk("b2b0_dr", 64'(EX_DR), 64'd1);
    chk("b2b0_we", 64'(EX_WE), 64'd1);
    chk("b2b0_a", 64'(EX_A), 64'h1000_0002);
    chk("b2b0_b", 64'(EX_B), 64'h1000_0003);
    chk("b2b0_imm", 64'(EX_IMM), 64'h0000_3000);
    chk("b2b0_pc", 64'(EX_PC), 64'h100);
    IF_IR = ins(8'h80, 4'd4, 4'd5, 16'h8001);
    IF_PC = 32'h104;
    #1;
    chk("b2b_ready1", 64'(IF_READY), 64'd1);
    tick();
    chk("b2b1_valid", 64'(EX_VALID), 64'd1);
    chk("b2b1_dr", 64'(EX_DR), 64'd4);
    chk("b2b1_a", 64'(EX_A), 64'h1000_0005);
    chk("b2b1_b", 64'(EX_B), 64'h1000_0008);
    chk("b2b1_imm", 64'(EX_IMM), 64'hFFFF_8001);
    chk("b2b1_pc", 64'(EX_PC), 64'h104);
    chk("b2b_busy", 64'(dut.u_sb.busy_q), 64'h0012);
    IF_VALID = 1'b0;
    tick();
    chk("drain_valid", 64'(EX_VALID), 64'd0);

    // RAW stall on R6
    IF_VALID = 1'b1;
    IF_IR    = ins(8'h90, 4'd6, 4'd2, 16'h0000);
    IF_PC    = 32'h108;
    tick();
    chk("load_dr", 64'(EX_DR), 64'd6);
    IF_IR = ins(8'h00, 4'd7, 4'd6, 16'h2000);
    IF_PC = 32'h10C;
    #1;
    chk("raw_stall0", 64'(IF_READY), 64'd0);
    tick();
    chk("raw_ex_drained", 64'(EX_VALID), 64'd0);
    chk("raw_stall1", 64'(IF_READY), 64'd0);
    tick();
    chk("raw_stall2", 64'(IF_READY), 64'd0);
    WB_WE = 1'b1;
    WB_DR = 4'd6;
    #1;
    chk("raw_release", 64'(IF_READY), 64'd1);
    tick();
    WB_WE = 1'b0;
    chk("raw_valid", 64'(EX_VALID), 64'd1);
    chk("raw_dr", 64'(EX_DR), 64'd7);
    chk("raw_a_bypass", 64'(EX_A), 64'hDEAD_BEEF);
    chk("raw_b", 64'(EX_B), 64'h1000_0002);
    chk("raw_busy", 64'(dut.u_sb.busy_q), 64'h0092);

    // WAW stall, then set-wins with same-cycle writeback
    IF_IR = ins(8'h90, 4'd6, 4'd2, 16'h0000);
    IF_PC = 32'h110;
    tick();
    chk("waw_busy_set", 64'(dut.u_sb.busy_q), 64'h00D2);
    IF_IR = ins(8'h90, 4'd6, 4'd3, 16'h0000);
    IF_PC = 32'h114;
    #1;
    chk("waw_stall", 64'(IF_READY), 64'd0);
    tick();
    WB_WE = 1'b1;
    WB_DR = 4'd6;
    #1;
    chk("waw_release", 64'(IF_READY), 64'd1);
    tick();
    WB_WE    = 1'b0;
    IF_VALID = 1'b0;
    chk("waw_valid", 64'(EX_VALID), 64'd1);
    chk("waw_pc", 64'(EX_PC), 64'h114);
    chk("set_wins_busy", 64'(dut.u_sb.busy_q), 64'h00D2);
    tick();
    chk("waw_drain", 64'(EX_VALID), 64'd0);

    // Backpressure
    EX_READY = 1'b0;
    IF_VALID = 1'b1;
    IF_IR    = ins(8'h80, 4'd8, 4'd2, 16'h0010);
    IF_PC    = 32'h200;
    tick();
    chk("bp_valid", 64'(EX_VALID), 64'd1);
    IF_IR = ins(8'h80, 4'd10, 4'd3, 16'h0005);
    IF_PC = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(IF_READY), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(EX_VALID), 64'd1);
      chk("bp_hold_dr", 64'(EX_DR), 64'd8);
      chk("bp_hold_pc", 64'(EX_PC), 64'h200);
      chk("bp_hold_imm", 64'(EX_IMM), 64'h10);
    end
    EX_READY = 1'b1;
    #1;
    chk("bp_release", 64'(IF_READY), 64'd1);
    tick();
    chk("bp_next_dr", 64'(EX_DR), 64'd10);
    chk("bp_next_pc", 64'(EX_PC), 64'h204);
    IF_VALID = 1'b0;
    tick();
    chk("bp_drain", 64'(EX_VALID), 64'd0);

    // Flush of a stalled R9 writer
    EX_READY = 1'b0;
    IF_VALID = 1'b1;
    IF_IR    = ins(8'h00, 4'd9, 4'd2, 16'h3000);
    IF_PC    = 32'h300;
    tick();
    chk("fl_pre_dr", 64'(EX_DR), 64'd9);
    chk("fl_pre_busy", 64'(dut.u_sb.busy_q), 64'h07D2);
    IF_IR = ins(8'h80, 4'd11, 4'd2, 16'h0000);
    IF_PC = 32'h304;
    FLUSH = 1'b1;
    #1;
    chk("fl_ready", 64'(IF_READY), 64'd0);
    tick();
    FLUSH = 1'b0;
    chk("fl_valid", 64'(EX_VALID), 64'd0);
    chk("fl_busy", 64'(dut.u_sb.busy_q), 64'h05D2);

    // Writeback to an idle register is a no-op
    IF_VALID = 1'b0;
    WB_WE    = 1'b1;
    WB_DR    = 4'd12;
    tick();
    WB_WE = 1'b0;
    chk("wb_idle_busy", 64'(dut.u_sb.busy_q), 64'h05D2);

    // Mid-stream asynchronous reset
    EX_READY = 1'b1;
    IF_VALID = 1'b1;
    tick();
    chk("mid_valid", 64'(EX_VALID), 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(EX_VALID), 64'd0);
    chk("mid_rst_dr", 64'(EX_DR), 64'd0);
    chk("mid_rst_busy", 64'(dut.u_sb.busy_q), 64'h0);
    chk("mid_rst_ready", 64'(IF_READY), 64'd0);
    IF_VALID = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(IF_READY), 64'd1);
    tick();
    chk("mid_rel_valid", 64'(EX_VALID), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode/issue stage; sits directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives SR1/SR2 read addresses to the register file.
- Tracks pending destination writes in a busy-bit scoreboard, stalls on RAW/WAW hazards, and registers decoded operands into the ID/EX pipeline register with its own valid/ready handshake.
- Writeback (WB_WE/WB_DR) is the same bus that drives the register file's WE/DR.

Parameters:
- BIT_WIDTH, 32: data/instruction/PC width.
- REG_WIDTH, 4: register address width; 2^REG_WIDTH architectural registers.
- IMM_WIDTH, 16: immediate field width, sign-extended to BIT_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IF_VALID  in  1  fetch presents an instruction.
- IF_READY  out  1  stage accepts the instruction this cycle.
- IF_IR  in  BIT_WIDTH  instruction word.
- IF_PC  in  BIT_WIDTH  PC of the instruction.
- RF_SR1, RF_SR2  out  REG_WIDTH  register-file read addresses, combinational from IF_IR.
- RF_SR1OUT, RF_SR2OUT  in  BIT_WIDTH  register-file read data; writeback bypass already applied.
- WB_WE  in  1  writeback commits this cycle.
- WB_DR  in  REG_WIDTH  writeback destination.
- FLUSH  in  1  branch mispredict; kill younger work.
- EX_VALID  out  1  ID/EX register holds an instruction.
- EX_READY  in  1  execute consumes this cycle.
- EX_OP  out  8  opcode.
- EX_DR  out  REG_WIDTH  destination register.
- EX_WE  out  1  instruction writes EX_DR.
- EX_A, EX_B  out  BIT_WIDTH  operand values.
- EX_IMM  out  BIT_WIDTH  sign-extended immediate.
- EX_PC  out  BIT_WIDTH  PC.

Behaviour:
- Fields:
  - OP = IR[31:24]; RD = IR[23:20]; RS1 = IR[19:16]; RS2 = IR[15:12]; IMM = IR[15:0]. Field positions are for REG_WIDTH = 4.
  - RF_SR1 = RS1 and RF_SR2 = RS2 at all times.
- Class decode on OP[7:4]:
  - 0x0 ALU-R: reads RS1, RS2; writes RD.
  - 0x8 ALU-I: reads RS1; writes RD.
  - 0x9 LOAD: reads RS1; writes RD.
  - 0x5 STORE: reads RS1, RS2; no write.
  - 0x2 BRANCH: reads RS1, RS2; no write.
  - 0xB JAL: reads RS1; writes RD.
  - Any other class: no reads, no write; passed through as a NOP.
- Scoreboard:
  - busy[2^REG_WIDTH]; all 0 at reset.
  - busy_eff[r] = busy[r] & ~(WB_WE & WB_DR == r). Same-cycle writeback clears the hazard; the register file bypasses DIN for that read.
- Hazard:
  - hazard = IF_VALID & ((reads RS1 & busy_eff[RS1]) | (reads RS2 & busy_eff[RS2]) | (writes & busy_eff[RD])).
- Handshake:
  - slot_free = ~EX_VALID | EX_READY.
  - IF_READY = slot_free & ~hazard & ~FLUSH.
  - Accept = IF_VALID & IF_READY.
  - On accept, at the next edge: EX_* loaded, EX_VALID = 1, EX_A = RF_SR1OUT, EX_B = RF_SR2OUT; busy[RD] set if writes.
  - EX_A/EX_B are loaded even for unused sources; the value is don't-care.
  - If EX_READY & EX_VALID and no accept: EX_VALID becomes 0.
  - If EX_VALID & ~EX_READY: all EX_* hold stable. No combinational EX_READY → IF_READY path except through slot_free.
- Simultaneous busy set/clear: on the same register in the same cycle, the set wins (new issue is younger).
- FLUSH, registered:
  - Next edge: EX_VALID = 0.
  - If EX_VALID & EX_WE and the instruction was not consumed this cycle, busy[EX_DR] is cleared (killed instruction never writes back).
  - If consumed this cycle (EX_READY), busy stays set.
  - Writeback clears in the same cycle still apply.
  - No accept during FLUSH.
- Reset:
  - Asynchronous on RESET_N low: EX_VALID = 0, EX_WE = 0, all other EX_* = 0, busy = 0.
  - IF_READY is 0 while reset is asserted.
  - Reset deassertion mid-transfer discards any pending instruction.
- Latency: 1 cycle IF accept → EX_VALID. Throughput 1 instruction/cycle without hazards.
- Boundary: the WB_DR clear applies even if busy[WB_DR] = 0 (no-op). Writing R0 is not special.

Decomposition:
- Shared package decode_pkg: opcode-class constants (CLS_ALUR, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL), field bit positions, and reads1/reads2/writes decode function.
- Sub-module scoreboard: busy vector with set port, writeback clear port, flush clear port, and two-read/one-dest hazard query.

Test Plan:
- Reset: RESET_N low mid-stream → EX_VALID = 0, busy all 0, IF_READY = 0; after release, IF_READY = 1 with EX_READY = 1.
- Back-to-back independent instructions:
  - Stimulus: ALU-R R1←R2,R3 then ALU-I R4←R5, EX_READY = 1.
  - Response: EX_VALID on 2 consecutive cycles; EX_A/EX_B equal RF data; busy[1] and busy[4] set.
- RAW stall:
  - Stimulus: LOAD R6, then ALU-R R7←R6,R2 with no writeback.
  - Response: IF_READY = 0 until WB_WE = 1, WB_DR = 6. The instruction is accepted in that same cycle with EX_A = writeback data.
- WAW plus set-wins:
  - Stimulus: writeback of R6 while issuing a new LOAD R6.
  - Response: the new LOAD issues; busy[6] remains 1 afterwards.
- Backpressure: EX_READY = 0 for 3 cycles with EX_VALID = 1 → EX_* stable, IF_READY = 0; EX_READY = 1 → next instruction accepted.
- Flush:
  - Stimulus: EX holds ALU-R R9 with EX_READY = 0; assert FLUSH with IF_VALID = 1.
  - Response: EX_VALID = 0 next cycle, busy[9] = 0, nothing accepted.
